// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, drives all datapath controls and counts retired instructions.
module mips_mc_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  ctrl_t            ctrl_c, ctrl_g;
  logic             retire;
  logic             rdy;

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = 2'b01;
        if (rdy) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = 2'b10;
        // IR is still stable here, so re-decoding lw/sw is safe
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
        retire            = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = 2'b10;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
        retire           = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_op        = 2'b01;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_src        = 2'b01;
        state_d              = S_FETCH;
        retire               = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = 2'b10;
        state_d          = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
        retire           = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_write = 1'b1;
        ctrl_c.pc_src   = 2'b10;
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_ILLEGAL: begin
        // PC already advanced in FETCH; the instruction is dropped, not retired
        ctrl_c.illegal_op = 1'b1;
        state_d           = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;

  // Reset overrides the FETCH decode so nothing strobes while rst_n is low
  assign ctrl_g = rst_n ? ctrl_c : '0;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_dst       = ctrl_g.reg_dst;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign pc_src        = ctrl_g.pc_src;
  assign illegal_op    = ctrl_g.illegal_op;
  assign state         = state_q;
  assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: instruction-level path model, directed
// corner cases, randomized opcode/mem_ready traffic and a narrow-counter wrap check.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        s_pc_write, s_pc_write_cond, s_i_or_d, s_mem_read, s_mem_write, s_ir_write;
  logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a, s_illegal_op;
  logic [1:0]  s_alu_src_b, s_alu_op, s_pc_src;
  logic [3:0]  s_state;
  logic [2:0]  s_instr_count;

  always #5 clk = ~clk;

  mips_mc_control #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  // Narrow counter instance so wrap-around is reached after only 8 retirements
  mips_mc_control #(.MEM_WAIT_EN(1'b1), .CNT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .i_or_d(s_i_or_d),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
    .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst), .reg_write(s_reg_write),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
    .pc_src(s_pc_src), .illegal_op(s_illegal_op), .state(s_state),
    .instr_count(s_instr_count)
  );

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
  //  reg_dst,reg_write,alu_src_a,alu_src_b[2],alu_op[2],pc_src[2],illegal_op}
  logic [16:0] dut_vec;
  assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_src, illegal_op};

  typedef struct {
    logic [5:0]       op;
    int               len;
    logic [4:0][3:0]  path;   // path[0] is the first state
    bit               retires;
  } instr_rec_t;

  instr_rec_t  itab[7];
  logic [16:0] exp_tab[16];

  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  int   nfail_print = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (nfail_print < 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      nfail_print++;
    end
  endtask

  function automatic int find_instr(input logic [5:0] op);
    for (int i = 0; i < 6; i++) if (itab[i].op == op) return i;
    return 6;
  endfunction

  // Runs one instruction through the model. rdy_pat bit k is mem_ready in cycle k
  // (cycles past 15 see mem_ready=1); if rnd is set mem_ready is random instead.
  task automatic run_instr(input logic [5:0] op, input logic [15:0] rdy_pat,
                           input bit rnd, output int cycles);
    int          idx;
    int          ti;
    logic        rdy;
    logic [3:0]  es;
    logic [16:0] ev;
    ti     = find_instr(op);
    idx    = 0;
    cycles = 0;
    opcode = op;
    while (idx < itab[ti].len && cycles < 60) begin
      rdy = rnd ? ($urandom_range(0, 2) != 0) : ((cycles < 16) ? rdy_pat[cycles] : 1'b1);
      mem_ready = rdy;
      #1;
      es = itab[ti].path[idx];
      ev = exp_tab[es];
      if (es == 4'd0 && !rdy) ev = ev & ~17'h10800;
      check("state", {28'd0, state}, {28'd0, es});
      check($sformatf("ctrl_s%0d", es), {15'd0, dut_vec}, {15'd0, ev});
      if (!((es == 4'd0 || es == 4'd3 || es == 4'd5) && !rdy)) idx++;
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 60) check("cycle_budget", 32'(cycles), 32'd0);
    if (itab[ti].retires) exp_cnt++;
    check("instr_count", instr_count, 32'(exp_cnt));
    check("small_count", {29'd0, s_instr_count}, {29'd0, 3'(exp_cnt)});
    $display("instr op=%b cycles=%0d state=%0d count=%0d", op, cycles, state, instr_count);
  endtask

  initial begin
    int   cyc;
    logic [5:0] rop;

    itab[0] = '{6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1};  // lw
    itab[1] = '{6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b1};  // sw
    itab[2] = '{6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b1};  // R-type
    itab[3] = '{6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b1};  // beq
    itab[4] = '{6'b001000, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 1'b1}; // addi
    itab[5] = '{6'b000010, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}, 1'b1}; // j
    itab[6] = '{6'b111111, 3, {4'd0, 4'd0, 4'd12, 4'd1, 4'd0}, 1'b0}; // illegal

    for (int i = 0; i < 16; i++) exp_tab[i] = '0;
    exp_tab[0]  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    exp_tab[1]  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    exp_tab[2]  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    exp_tab[3]  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    exp_tab[4]  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    exp_tab[5]  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    exp_tab[6]  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    exp_tab[7]  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    exp_tab[8]  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    exp_tab[9]  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    exp_tab[10] = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    exp_tab[11] = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    exp_tab[12] = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    // Reset: all controls forced low even though FETCH would drive mem_read
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", {15'd0, dut_vec}, 32'd0);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Every instruction class once with mem_ready held high
    for (int i = 0; i < 7; i++) begin
      run_instr(itab[i].op, 16'hFFFF, 1'b0, cyc);
      check($sformatf("latency_%0d", i), 32'(cyc), 32'(itab[i].len));
    end

    // FETCH stalled 3 cycles, then an R-type
    run_instr(6'b000000, 16'hFFF8, 1'b0, cyc);
    check("fetch_wait_lat", 32'(cyc), 32'd7);
    // lw with mem_ready low for 2 cycles in MEMRD
    run_instr(6'b100011, 16'hFFE7, 1'b0, cyc);
    check("lw_wait_lat", 32'(cyc), 32'd7);
    // sw holding in MEMWR for 2 cycles
    run_instr(6'b101011, 16'hFFE7, 1'b0, cyc);
    check("sw_wait_lat", 32'(cyc), 32'd6);
    // Another unsupported opcode
    run_instr(6'b000011, 16'hFFFF, 1'b0, cyc);
    check("illegal_lat", 32'(cyc), 32'd3);

    // Randomized opcodes and mem_ready; crosses the 3-bit counter wrap many times
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
      else rop = itab[$urandom_range(0, 5)].op;
      run_instr(rop, 16'hFFFF, 1'b1, cyc);
    end

    // Asynchronous reset while holding in MEMWR
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("memwr_state", {28'd0, state}, 32'd5);
    check("memwr_strobe", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_write", {31'd0, mem_write}, 32'd0);
    check("async_ctrl", {15'd0, dut_vec}, 32'd0);
    check("async_state", {28'd0, state}, 32'd0);
    check("async_count", instr_count, 32'd0);
    check("async_small_count", {29'd0, s_instr_count}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000000, 16'hFFFF, 1'b0, cyc);
    check("post_rst_lat", 32'(cyc), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select, stalls on a memory-ready handshake, and counts retired instructions.
- Sits beside the datapath inside the MIPS top level and takes the IR opcode field as input.

Parameters:
MEM_WAIT_EN, 1, 1: honour mem_ready in FETCH/MEMRD/MEMWR; 0: treat mem_ready as always 1
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  regfile write data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination register: 0 = rt, 1 = rd
reg_write  out  1  regfile write enable
alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register
alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state, for debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH (0), instr_count = 0.
- While rst_n is low, all control outputs are forced to 0, overriding the state decode.
- Control outputs are Moore-decoded from state, except where gated by mem_ready. Any output not listed for a state is 0.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6
  - ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, ILLEGAL = 12
  - Codes 13–15 go to FETCH on the next clock.
- Per-state outputs and transitions:
  - FETCH: mem_read = 1, alu_src_b = 01. ir_write and pc_write are asserted only while mem_ready = 1. Goes to DECODE when mem_ready = 1; otherwise stays in FETCH.
  - DECODE: alu_src_b = 11. Opcode selects the next state:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → ILLEGAL
  - MEMADR: alu_src_a = 1, alu_src_b = 10. lw → MEMRD, sw → MEMWR. Opcode is sampled again here; the IR is stable.
  - MEMRD: mem_read = 1, i_or_d = 1. Goes to MEMWB when mem_ready = 1; otherwise holds.
  - MEMWB: mem_to_reg = 1, reg_write = 1. Goes to FETCH.
  - MEMWR: mem_write = 1, i_or_d = 1. Goes to FETCH when mem_ready = 1; otherwise holds with mem_write still asserted.
  - EXEC: alu_src_a = 1, alu_op = 10. Goes to ALUWB.
  - ALUWB: reg_dst = 1, reg_write = 1. Goes to FETCH.
  - BRANCH: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_src = 01. Goes to FETCH.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10. Goes to ADDIWB.
  - ADDIWB: reg_write = 1. Goes to FETCH.
  - JUMP: pc_write = 1, pc_src = 10. Goes to FETCH.
  - ILLEGAL: illegal_op = 1. Goes to FETCH. The PC is already advanced, so the instruction is skipped.
- Latency with mem_ready held at 1:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j, illegal = 3 cycles
  - Each low cycle of mem_ready in a wait state adds 1 cycle.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It does not increment from ILLEGAL. It wraps from 2^CNT_W−1 to 0.
- No write enable (pc_write, ir_write, reg_write, mem_write) is asserted in any cycle other than those listed above.
- Reset asserted mid-instruction aborts the instruction: outputs go to 0 immediately. On release, sequencing restarts at FETCH.

Test Plan:
- Reset release, mem_ready = 1, IR = R-type (000000): states 0,1,6,7,0. reg_write = 1 and reg_dst = 1 in state 7 only. instr_count = 1 after 4 cycles.
- lw, mem_ready = 1: states 0,1,2,3,4. Then lw with mem_ready low for 2 cycles in MEMRD: 7 cycles total, mem_read held high in MEMRD, reg_write only in MEMWB.
- FETCH with mem_ready low for 3 cycles: ir_write = 0 and pc_write = 0 throughout the wait. Both are 1 in the single cycle mem_ready = 1, then state = DECODE.
- beq, j, addi, sw sequences: beq gives pc_write_cond = 1 and pc_src = 01 in state 8. j gives pc_write = 1 and pc_src = 10. addi reaches state 10 with reg_dst = 0. sw holds mem_write = 1 until mem_ready.
- Opcode 111111: illegal_op pulses 1 cycle in state 12. Back in FETCH after 3 cycles. instr_count unchanged.
- instr_count preloaded to 0xFFFFFFFF via force, then one R-type retires → 0. Also rst_n pulsed low while in MEMWR: mem_write drops asynchronously, state = 0, instr_count = 0.
